// File: rtl/reg_pipe_if.sv
// reg_pipe_if: valid/ready upstream and downstream handshake bundle for reg_pipe
interface reg_pipe_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] datain;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] reg_out;
  modport master (output in_valid, datain, out_ready, input in_ready, out_valid, reg_out);
  modport slave  (input in_valid, datain, out_ready, output in_ready, out_valid, reg_out);
endinterface

// File: rtl/reg_pipe.sv
// reg_pipe: elastic register chain with valid/ready, clock enable, sync clear and occupancy count.
// Define REG_PIPE_STATS_EN to add a saturating stall_cnt output.
module reg_pipe #(
  parameter int               WIDTH     = 16,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int              OW        = $clog2(STAGES + 1)
) (
  input  logic          clk,
  input  logic          aclr_n,
  input  logic          sclr_n,
  input  logic          clk_ena,
  reg_pipe_if.slave     bus,
`ifdef REG_PIPE_STATS_EN
  output logic [15:0]   stall_cnt,
`endif
  output logic [OW-1:0] occupancy
);
  logic [STAGES-1:0] v, nv, rdy, vin;
  logic [WIDTH-1:0]  d [STAGES];
  logic [WIDTH-1:0]  nd [STAGES];
  logic [WIDTH-1:0]  din [STAGES];
  logic [OW-1:0]     ncnt;
  assign vin[0] = bus.in_valid;
  assign din[0] = bus.datain;
  for (genvar i = 1; i < STAGES; i++) begin : g_link
    assign vin[i] = v[i-1];
    assign din[i] = d[i-1];
  end
  // A stage can advance unless it and every stage downstream of it is full and stalled
  for (genvar i = 0; i < STAGES; i++) begin : g_rdy
    assign rdy[i] = ~(&v[STAGES-1:i]) | bus.out_ready;
  end
  assign bus.in_ready  = clk_ena & sclr_n & rdy[0];
  assign bus.out_valid = clk_ena & v[STAGES-1];
  assign bus.reg_out   = d[STAGES-1];
  always_comb begin
    nv = v;
    nd = d;
    if (clk_ena && !sclr_n) begin
      nv = '0;
      for (int i = 0; i < STAGES; i++) nd[i] = RESET_VAL;
    end else if (clk_ena) begin
      for (int i = 0; i < STAGES; i++) begin
        if (rdy[i]) begin
          nv[i] = vin[i];
          nd[i] = vin[i] ? din[i] : d[i];
        end
      end
    end
    ncnt = '0;
    for (int i = 0; i < STAGES; i++) ncnt = ncnt + OW'(nv[i]);
  end
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      v         <= '0;
      occupancy <= '0;
      for (int i = 0; i < STAGES; i++) d[i] <= RESET_VAL;
    end else begin
      v         <= nv;
      occupancy <= ncnt;
      for (int i = 0; i < STAGES; i++) d[i] <= nd[i];
    end
  end
`ifdef REG_PIPE_STATS_EN
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) stall_cnt <= '0;
    else if (clk_ena && !sclr_n) stall_cnt <= '0;
    else if (clk_ena && v[STAGES-1] && !bus.out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe: directed self-checking bench for reg_pipe (WIDTH=16, STAGES=3, RESET_VAL=0)
module tb_reg_pipe;
  localparam int W = 16;
  localparam int S = 3;
  logic       clk = 1'b0;
  logic       aclr_n = 1'b0;
  logic       sclr_n = 1'b1;
  logic       clk_ena = 1'b1;
  logic [1:0] occupancy;
`ifdef REG_PIPE_STATS_EN
  logic [15:0] stall_cnt;
`endif
  int checks = 0;
  int passed = 0;
  reg_pipe_if #(.WIDTH(W)) bus ();
  reg_pipe #(.WIDTH(W), .STAGES(S), .RESET_VAL(16'h0000)) dut (
    .clk       (clk),
    .aclr_n    (aclr_n),
    .sclr_n    (sclr_n),
    .clk_ena   (clk_ena),
    .bus       (bus.slave),
`ifdef REG_PIPE_STATS_EN
    .stall_cnt (stall_cnt),
`endif
    .occupancy (occupancy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic drive(input logic iv, input logic [15:0] di, input logic orr);
    bus.in_valid  = iv;
    bus.datain    = di;
    bus.out_ready = orr;
    #1;
  endtask
  initial begin
    int got;
    int first;
    drive(0, 16'h0, 0);
    tick();
    tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_occ", occupancy, 0);
    check("rst_reg_out", bus.reg_out, 16'h0000);
    aclr_n = 1'b1;
    tick();
    // async reset while two words are in flight
    drive(1, 16'h1111, 0);
    check("fill_in_ready", bus.in_ready, 1);
    tick();
    drive(1, 16'h2222, 0);
    tick();
    drive(0, 16'h0, 0);
    check("fill_occ", occupancy, 2);
    tick();
    check("fill_out_valid", bus.out_valid, 1);
    check("fill_reg_out", bus.reg_out, 16'h1111);
    #3 aclr_n = 1'b0;
    #1;
    check("aclr_out_valid", bus.out_valid, 0);
    check("aclr_occ", occupancy, 0);
    check("aclr_reg_out", bus.reg_out, 16'h0000);
    tick();
    aclr_n = 1'b1;
    tick();
    // streaming with out_ready held high
    got = 0;
    first = -1;
    for (int c = 0; c < 13; c++) begin
      drive(c < 8, 16'(c + 1), 1);
      if (c < 8) check("stream_in_ready", bus.in_ready, 1);
      if (bus.out_valid) begin
        if (first < 0) first = c;
        check("stream_data", bus.reg_out, 32'(got + 1));
        got++;
      end
      tick();
    end
    check("stream_latency", 32'(first), 3);
    check("stream_count", 32'(got), 8);
    // backpressure
    for (int k = 1; k <= 3; k++) begin
      drive(1, 16'(k), 0);
      check("bp_in_ready", bus.in_ready, 1);
      tick();
    end
    drive(1, 16'h0004, 0);
    check("bp_occ_full", occupancy, 3);
    check("bp_full_in_ready", bus.in_ready, 0);
    tick();
    check("bp_hold_occ", occupancy, 3);
    check("bp_hold_reg_out", bus.reg_out, 16'h0001);
    drive(1, 16'h0004, 1);
    check("bp_release_in_ready", bus.in_ready, 1);
    check("bp_release_out_valid", bus.out_valid, 1);
    check("bp_release_reg_out", bus.reg_out, 16'h0001);
    tick();
    drive(0, 16'h0, 1);
    check("bp_after_occ", occupancy, 3);
    check("bp_after_reg_out", bus.reg_out, 16'h0002);
    tick();
    check("bp_drain3", bus.reg_out, 16'h0003);
    tick();
    check("bp_drain4", bus.reg_out, 16'h0004);
    check("bp_drain4_valid", bus.out_valid, 1);
    tick();
    check("empty_out_valid", bus.out_valid, 0);
    check("empty_occ", occupancy, 0);
    check("empty_reg_out_kept", bus.reg_out, 16'h0004);
    // clock enable freeze
    drive(1, 16'hAAAA, 1);
    tick();
    drive(1, 16'h5555, 1);
    tick();
    clk_ena = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1, 16'h1234, 1);
      check("ena_in_ready", bus.in_ready, 0);
      check("ena_out_valid", bus.out_valid, 0);
      tick();
    end
    check("ena_occ", occupancy, 2);
    clk_ena = 1'b1;
    drive(0, 16'h0, 1);
    tick();
    check("ena_word1_valid", bus.out_valid, 1);
    check("ena_word1", bus.reg_out, 16'hAAAA);
    tick();
    check("ena_word2", bus.reg_out, 16'h5555);
    tick();
    check("ena_drained", bus.out_valid, 0);
    // synchronous clear
    drive(1, 16'hB001, 0);
    tick();
    drive(1, 16'hB002, 0);
    tick();
    check("sclr_pre_occ", occupancy, 2);
    sclr_n = 1'b0;
    drive(1, 16'hCCCC, 1);
    check("sclr_in_ready", bus.in_ready, 0);
    tick();
    sclr_n = 1'b1;
    drive(0, 16'h0, 1);
    check("sclr_occ", occupancy, 0);
    check("sclr_out_valid", bus.out_valid, 0);
    check("sclr_reg_out", bus.reg_out, 16'h0000);
    tick();
    check("sclr_no_accept", occupancy, 0);
    drive(1, 16'hD001, 0);
    tick();
    drive(1, 16'hD002, 0);
    tick();
    clk_ena = 1'b0;
    sclr_n = 1'b0;
    drive(0, 16'h0, 0);
    tick();
    clk_ena = 1'b1;
    sclr_n = 1'b1;
    drive(0, 16'h0, 1);
    check("sclr_gated_occ", occupancy, 2);
    tick();
    check("sclr_gated_word1", bus.reg_out, 16'hD001);
    tick();
    check("sclr_gated_word2", bus.reg_out, 16'hD002);
    tick();
`ifdef REG_PIPE_STATS_EN
    sclr_n = 1'b0;
    drive(0, 16'h0, 0);
    tick();
    sclr_n = 1'b1;
    check("stats_clear", stall_cnt, 0);
    for (int k = 1; k <= 3; k++) begin
      drive(1, 16'(k), 0);
      tick();
    end
    drive(0, 16'h0, 0);
    check("stats_fill", stall_cnt, 0);
    for (int k = 0; k < 10; k++) tick();
    check("stats_ten", stall_cnt, 10);
    for (int k = 0; k < 70000; k++) tick();
    check("stats_saturate", stall_cnt, 16'hFFFF);
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
